plic_target_core: RTL
=====================

Name: plic_target_core

Overview:
- Receiving end of the interrupt gateway handshake: collects valid pulses from NSRC per-source gateways into pending bits.
- Arbitrates pending sources by programmable priority for a single hart context, drives the hart interrupt line, and serves claim/complete.
- Returns a one-cycle complete strobe to the originating gateway so it may re-arm.
- Sits between the gateway array and the core's external-interrupt input; configured over a simple register write/read port.

Parameters:
- NSRC, 8, number of interrupt sources (1..31); source IDs are 1..NSRC, ID 0 means "none".
- PRIO_W, 3, priority field width; priority 0 means "never interrupt".

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- gw_valid  input  NSRC  bit i = gateway for source ID i+1 presents an interrupt
- gw_ready  output  NSRC  bit i = core accepts from source i+1
- gw_complete  output  NSRC  bit i = one-cycle completion strobe to gateway i+1
- cfg_we  input  1  config write strobe
- cfg_addr  input  6  0 = threshold, 1..NSRC = priority of that ID, NSRC+1 = enable vector
- cfg_wdata  input  32  write data (LSBs used)
- cfg_rdata  output  32  combinational read of cfg_addr, zero-extended; unmapped addresses read 0
- claim_req  input  1  hart claim strobe
- claim_id  output  5  current best ID (combinational), 0 if none
- complete_valid  input  1  hart completion strobe
- complete_id  input  5  ID being completed
- irq  output  1  registered interrupt request to hart

Behaviour:
- Reset: pending, priority[], enable, threshold all cleared. Outputs gw_complete=0 and irq=0. gw_ready is all-ones after reset because pending is 0.
- gw_ready[i] = ~pending[i]. When gw_valid[i] & gw_ready[i] in cycle t, pending[i]=1 from t+1.
- Eligible[i] = pending[i] & enable[i] & (priority[i] != 0).
- claim_id is combinational from current registers: the eligible ID with the highest priority, ties going to the lowest ID, 0 if none. Threshold does not gate claim_id.
- Claim: in a cycle with claim_req=1 and claim_id!=0, pending[claim_id-1] clears at the next edge. claim_req with claim_id=0 has no effect.
- Back-to-back claim_req in consecutive cycles returns distinct IDs, because arbitration is combinational from pending.
- irq register: irq <= (exists eligible i with priority[i] > threshold), updated every cycle. It lags pending/config by 1 cycle.
- Complete: complete_valid with 1 <= complete_id <= NSRC makes gw_complete[complete_id-1]=1 for exactly the next cycle, with all other bits 0. ID 0 or ID > NSRC is ignored. No check is made that the ID was claimed.
- Simultaneous events:
  - Set and claim of the same bit cannot coincide, since ready is low while pending.
  - A claim and a complete in the same cycle are both processed.
  - A gateway valid for a source whose bit is cleared by a claim this cycle is not accepted (ready was 0). It is accepted from the following cycle.
  - A cfg write and a claim in the same cycle: claim_id uses the pre-write values.
- Config writes:
  - Threshold and priority take wdata[PRIO_W-1:0].
  - The enable vector takes wdata[NSRC-1:0].
  - A write is effective at the next edge.
- Disabling a pending source keeps it pending. It becomes eligible again when re-enabled.
- Reset mid-operation clears pending without any gw_complete strobes. Gateways are reset by the same reset.

Test Plan:
- Reset, then read every address -> cfg_rdata=0, irq=0, claim_id=0, gw_ready all ones, gw_complete=0.
- Set prio[3]=2 and enable 0x04, pulse gw_valid[2] -> gw_ready[2]=0 next cycle, claim_id=3, irq=1 one cycle later. claim_req -> pending clears, claim_id=0, irq falls next cycle.
- Prio[2]=5, prio[5]=5, prio[7]=6, all enabled and pending -> claims in consecutive cycles return 7, 2, 5, then 0.
- Threshold=4, single source with prio 4 pending -> irq=0 but claim_id = that ID. Raise prio to 5 -> irq=1 two cycles after the write.
- complete_valid with id=3 -> gw_complete=0x04 for exactly one cycle. id=0 and id=9 (NSRC=8) -> no strobe.
- Two sources pending, reset asserted for one cycle -> all pending cleared, irq=0, no gw_complete strobe. A valid after reset is accepted normally.

Source files
------------

// File: rtl/plic_target_core.sv
// plic_target_core: single-context interrupt target.
// Collects gateway valid pulses into pending bits, arbitrates eligible sources by
// programmable priority, drives a registered irq line, and serves claim/complete
// with a one-cycle completion strobe back to the originating gateway.

// Per-source slot: pending bit, priority register and completion strobe.
module plic_src_slot #(
    parameter int PRIO_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set,
    input  logic              clr,
    input  logic              prio_we,
    input  logic [PRIO_W-1:0] prio_wdata,
    input  logic              done,
    output logic              pending,
    output logic [PRIO_W-1:0] prio,
    output logic              complete
);

    // Pending: set by an accepted gateway pulse, cleared by a claim of this ID.
    // set only fires while pending is low, so set and clr never collide.
    always_ff @(posedge clk) begin
        if (reset)    pending <= 1'b0;
        else if (clr) pending <= 1'b0;
        else if (set) pending <= 1'b1;
    end

    // Priority register, written through the config port.
    always_ff @(posedge clk) begin
        if (reset)        prio <= '0;
        else if (prio_we) prio <= prio_wdata;
    end

    // Completion strobe: high for exactly the cycle after the hart completes this ID.
    always_ff @(posedge clk) begin
        if (reset) complete <= 1'b0;
        else       complete <= done;
    end

endmodule

module plic_target_core #(
    parameter int NSRC   = 8,
    parameter int PRIO_W = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] gw_valid,
    output logic [NSRC-1:0] gw_ready,
    output logic [NSRC-1:0] gw_complete,
    input  logic            cfg_we,
    input  logic [5:0]      cfg_addr,
    input  logic [31:0]     cfg_wdata,
    output logic [31:0]     cfg_rdata,
    input  logic            claim_req,
    output logic [4:0]      claim_id,
    input  logic            complete_valid,
    input  logic [4:0]      complete_id,
    output logic            irq
);

    logic [NSRC-1:0]             pending;
    logic [NSRC-1:0]             enable;
    logic [NSRC-1:0]             eligible;
    logic [NSRC-1:0]             claim_hit;
    logic [NSRC-1:0]             prio_we;
    logic [NSRC-1:0]             done;
    logic [NSRC-1:0][PRIO_W-1:0] prio;
    logic [PRIO_W-1:0]           threshold;
    logic                        irq_next;
    logic                        unused_wdata;

    // Only the low bits of write data are meaningful; the rest are dropped.
    assign unused_wdata = ^cfg_wdata;

    // A gateway may hand over a new interrupt only while its bit is idle.
    assign gw_ready = ~pending;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        assign claim_hit[g] = claim_req && (claim_id == 5'(g + 1));
        assign prio_we[g]   = cfg_we && (cfg_addr == 6'(g + 1));
        assign done[g]      = complete_valid && (complete_id == 5'(g + 1));
        assign eligible[g]  = pending[g] && enable[g] && (prio[g] != '0);

        plic_src_slot #(.PRIO_W(PRIO_W)) u_slot (
            .clk        (clk),
            .reset      (reset),
            .set        (gw_valid[g] && !pending[g]),
            .clr        (claim_hit[g]),
            .prio_we    (prio_we[g]),
            .prio_wdata (cfg_wdata[PRIO_W-1:0]),
            .done       (done[g]),
            .pending    (pending[g]),
            .prio       (prio[g]),
            .complete   (gw_complete[g])
        );
    end

    // Threshold and enable vector registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            threshold <= '0;
            enable    <= '0;
        end else if (cfg_we) begin
            if (cfg_addr == 6'd0)            threshold <= cfg_wdata[PRIO_W-1:0];
            if (cfg_addr == 6'(NSRC + 1))    enable    <= cfg_wdata[NSRC-1:0];
        end
    end

    // Arbitration: strictly-greater compare walking up from ID 1 keeps the lowest ID on ties.
    always_comb begin
        logic [PRIO_W-1:0] best_prio;
        best_prio = '0;
        claim_id  = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (eligible[i] && (prio[i] > best_prio)) begin
                best_prio = prio[i];
                claim_id  = 5'(i + 1);
            end
        end
    end

    // Interrupt request condition: some eligible source beats the threshold.
    always_comb begin
        irq_next = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (eligible[i] && (prio[i] > threshold)) irq_next = 1'b1;
        end
    end

    // Registered irq, one cycle behind pending/config.
    always_ff @(posedge clk) begin
        if (reset) irq <= 1'b0;
        else       irq <= irq_next;
    end

    // Config read-back, zero-extended; unmapped addresses read 0.
    always_comb begin
        cfg_rdata = '0;
        if (cfg_addr == 6'd0) begin
            cfg_rdata = 32'(threshold);
        end else if (cfg_addr == 6'(NSRC + 1)) begin
            cfg_rdata = 32'(enable);
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (cfg_addr == 6'(i + 1)) cfg_rdata = 32'(prio[i]);
            end
        end
    end

endmodule
